// File: rtl/wb_mem_slave_pkg.sv
// rtl/wb_mem_slave_pkg.sv - shared Wishbone cycle-type codes and FSM state encoding
//
// Purpose : constants used by wb_mem_slave and its bench.
// Contents: CTI_* cycle type identifiers, state_e FSM encoding.

package wb_mem_slave_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/wb_mem_slave_ram.sv
// rtl/wb_mem_slave_ram.sv - single-port RAM, synchronous read, per-byte write enable
//
// Purpose : backing store for wb_mem_slave (DEPTH x DW).
// Ports   : clk_i     clock
//           rst_n_i   async active-low reset (read-data register only; array not reset)
//           addr_i    word address
//           we_i      write enable
//           be_i      byte-lane enables for writes
//           wdata_i   write data
//           rdata_o   registered read data (read-before-write)

module wb_mem_slave_ram #(
  parameter int DW    = 64,
  parameter int DEPTH = 512,
  localparam int SW   = DW / 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic [AW-1:0] addr_i,
  input  logic          we_i,
  input  logic [SW-1:0] be_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < SW; b++) begin
        if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  // Only the output register is reset so the read port reads zero after reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rdata_q <= '0;
    else          rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_mem_slave.sv
// rtl/wb_mem_slave.sv - Wishbone B3 memory slave with wait states, bursts, ERR/RTY
//
// Purpose : byte-enabled RAM window at BASE_ADR serving classic cycles and linear
//           incrementing bursts (one beat per clock after WAIT_STATES idle cycles).
// Ports   : clk, rstn (async active-low)
//           wb_adr_i/wb_dat_i/wb_sel_i/wb_cti_i/wb_we_i/wb_cyc_i/wb_stb_i  master request
//           wb_dat_o/wb_ack_o/wb_err_o/wb_rty_o                            registered response
//           mem_en  0 = new accesses are answered with RTY

import wb_mem_slave_pkg::*;

module wb_mem_slave #(
  parameter int          c_DATA_WIDTH = 64,
  parameter logic [31:0] BASE_ADR     = 32'h1000,
  parameter int          DEPTH        = 512,
  parameter int          WAIT_STATES  = 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [c_DATA_WIDTH-1:0]   wb_dat_i,
  output logic [c_DATA_WIDTH-1:0]   wb_dat_o,
  input  logic [31:0]               wb_adr_i,
  input  logic [c_DATA_WIDTH/8-1:0] wb_sel_i,
  input  logic [2:0]                wb_cti_i,
  input  logic                      wb_we_i,
  input  logic                      wb_cyc_i,
  input  logic                      wb_stb_i,
  output logic                      wb_ack_o,
  output logic                      wb_err_o,
  output logic                      wb_rty_o,
  input  logic                      mem_en
);

  localparam int          SEL_W     = c_DATA_WIDTH / 8;
  localparam int          ADR_LSB   = $clog2(SEL_W);
  localparam int          IDX_W     = $clog2(DEPTH);
  localparam logic [31:0] WIN_BYTES = 32'(DEPTH * SEL_W);
  // The request cycle itself counts as one wait, so the counter starts one lower.
  localparam logic [3:0]  WS_LOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e           state_q, state_d;
  logic [3:0]       wait_q, wait_d;
  logic [IDX_W-1:0] cur_q, cur_d;     // word index of the beat currently being answered
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             rty_q, rty_d;

  logic [31:0]      offset;
  logic             adr_in_win;
  logic [IDX_W-1:0] adr_idx;
  logic             is_incr, is_eob;
  logic             req, term, first_resp, burst_beat, nxt_oob;
  logic [IDX_W:0]   nxt;
  logic             ram_we;
  logic [IDX_W-1:0] ram_addr;

  assign offset     = wb_adr_i - BASE_ADR;
  assign adr_in_win = (offset < WIN_BYTES);   // below-base addresses wrap to large offsets
  assign adr_idx    = offset[ADR_LSB +: IDX_W];
  assign is_incr    = (wb_cti_i == CTI_INCR);
  assign is_eob     = (wb_cti_i == CTI_EOB);

  // A beat terminates on the edge where ACK is up and the master still strobes.
  assign term    = ack_q & wb_stb_i;
  assign nxt     = {1'b0, cur_q} + {{IDX_W{1'b0}}, term};
  assign nxt_oob = nxt[IDX_W];

  // rty_q masks the strobe that is being retried this very cycle.
  assign req = wb_cyc_i & wb_stb_i & ~rty_q;

  assign first_resp = wb_cyc_i && wb_stb_i &&
                      ((state_q == ST_IDLE && !rty_q && mem_en && WAIT_STATES == 0) ||
                       (state_q == ST_WAIT && wait_q == 4'd0));

  // Next burst response, unless the beat terminating now was marked end-of-burst.
  assign burst_beat = (state_q == ST_BURST) && wb_cyc_i && wb_stb_i && !(term && is_eob);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      cur_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rty_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cur_q   <= cur_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rty_q   <= rty_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    cur_d   = cur_q;
    if (!wb_cyc_i) begin
      state_d = ST_IDLE;
      wait_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req && mem_en && WAIT_STATES != 0) begin
            wait_d  = WS_LOAD;
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_q != 4'd0) wait_d = wait_q - 4'd1;
        end
        ST_BURST: begin
          if (wb_stb_i && !burst_beat) state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
      if (first_resp) begin
        cur_d   = adr_idx;
        state_d = (adr_in_win && is_incr) ? ST_BURST : ST_DONE;
      end
      if (burst_beat) begin
        if (nxt_oob) state_d = ST_DONE;
        else         cur_d   = nxt[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    ack_d = 1'b0;
    err_d = 1'b0;
    rty_d = 1'b0;
    if (state_q == ST_IDLE && req && !mem_en) rty_d = 1'b1;
    if (first_resp) begin
      ack_d = adr_in_win;
      err_d = !adr_in_win;
    end
    if (burst_beat) begin
      ack_d = !nxt_oob;
      err_d = nxt_oob;
    end
  end

  // Writes land on the terminating edge of an acked beat; reads fetch the word
  // for the response being issued so data arrives together with ACK.
  assign ram_we   = ack_q & wb_cyc_i & wb_stb_i & wb_we_i;
  assign ram_addr = wb_we_i ? cur_q :
                    (state_q == ST_BURST) ? nxt[IDX_W-1:0] : adr_idx;

  wb_mem_slave_ram #(
    .DW    (c_DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (clk),
    .rst_n_i (rstn),
    .addr_i  (ram_addr),
    .we_i    (ram_we),
    .be_i    (wb_sel_i),
    .wdata_i (wb_dat_i),
    .rdata_o (wb_dat_o)
  );

  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_rty_o = rty_q;

endmodule
